j1_boot_ctrl: RTL and testbench

Boot sequencer for the j1 core.
- Holds the CPU in reset after power-up.
- Receives a framed program image over a byte stream (UART receiver side) and writes it word-by-word into code RAM through that RAM's second write port.
- Verifies a checksum, then releases the CPU to execute from address 0.
- Returns the CPU to reset and reloads on a `reload` request.

---
 rtl/j1_boot_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_j1_boot_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_boot_ctrl.sv
// rtl/j1_boot_ctrl.sv - j1 boot sequencer: loads a framed image over a byte stream into code RAM, then releases the CPU.
// Optional autostart-on-timeout is enabled by defining J1_BOOT_AUTOSTART_EN.
module j1_boot_ctrl #(
  parameter int          ADDR_W         = 13,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              cr_we,
  output logic [ADDR_W-1:0] cr_addr,
  output logic [15:0]       cr_wdata,
  output logic              cpu_resetq,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_RUN
  } state_t;

  localparam int          CW        = ADDR_W + 1;
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [7:0]  MAGIC     = 8'hA5;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_len;
  logic [7:0]        r_csum;
  logic [CW-1:0]     r_cnt;
  logic [7:0]        r_lo;
  logic              r_cr_we;
  logic [ADDR_W-1:0] r_cr_addr;
  logic [15:0]       r_cr_wdata;
  logic              r_cpu_resetq;
  logic              r_err;

  logic              w_acc;
  logic              w_magic;
  logic [15:0]       w_len_full;
  logic              w_len_bad;
  logic [CW-1:0]     w_cnt_inc;
  logic              w_last_word;
  logic [7:0]        w_csum_nxt;
  logic              w_csum_ok;
  logic              w_tmo_hit;

  assign rx_ready    = (r_state != S_RUN);
  assign w_acc       = rx_valid && rx_ready;
  assign w_magic     = (rx_data == MAGIC);
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_len_bad   = ({16'd0, w_len_full} > MAX_WORDS);
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last_word = (32'(w_cnt_inc) == {16'd0, r_len});
  assign w_csum_nxt  = r_csum ^ rx_data;
  assign w_csum_ok   = (rx_data == r_csum);

  assign cr_we      = r_cr_we;
  assign cr_addr    = r_cr_addr;
  assign cr_wdata   = r_cr_wdata;
  assign cpu_resetq = r_cpu_resetq;
  assign err        = r_err;
  assign busy       = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                      (r_state == S_DATA_LO) || (r_state == S_DATA_HI) ||
                      (r_state == S_CSUM);

`ifdef J1_BOOT_AUTOSTART_EN
  logic [23:0] r_tmo;
  logic        r_started;
  logic        w_tmo_run;

  // Only an untouched IDLE (no magic seen since reset/reload) may time out into RUN.
  assign w_tmo_run = (r_state == S_IDLE) && !r_cpu_resetq && !r_started;
  assign w_tmo_hit = w_tmo_run && (r_tmo == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tmo     <= 24'd0;
      r_started <= 1'b0;
    end else if (r_state == S_IDLE && w_acc && w_magic) begin
      r_tmo     <= 24'd0;
      r_started <= 1'b1;
    end else if (r_state == S_RUN && reload) begin
      r_tmo     <= 24'd0;
      r_started <= 1'b0;
    end else if (w_tmo_run) begin
      r_tmo <= r_tmo + 24'd1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && w_magic) begin
          w_state_nxt = S_LEN_LO;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RUN;
        end
      end
      S_LEN_LO: begin
        if (w_acc) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_acc) begin
          if (w_len_full == 16'd0) begin
            w_state_nxt = S_CSUM;
          end else if (w_len_bad) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (w_acc) w_state_nxt = S_DATA_HI;
      end
      S_DATA_HI: begin
        if (w_acc) w_state_nxt = w_last_word ? S_CSUM : S_DATA_LO;
      end
      S_CSUM: begin
        if (w_acc) w_state_nxt = w_csum_ok ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (reload) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_len        <= 16'd0;
      r_csum       <= 8'd0;
      r_cnt        <= '0;
      r_lo         <= 8'd0;
      r_cr_we      <= 1'b0;
      r_cr_addr    <= '0;
      r_cr_wdata   <= 16'd0;
      r_cpu_resetq <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cr_we      <= 1'b0;
      // CPU runs exactly while the FSM sits in RUN, switched on the entering edge.
      r_cpu_resetq <= (w_state_nxt == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_magic) begin
            r_csum <= 8'd0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (w_acc) begin
            r_len[7:0] <= rx_data;
            r_csum     <= w_csum_nxt;
          end
        end
        S_LEN_HI: begin
          if (w_acc) begin
            r_len[15:8] <= rx_data;
            r_csum      <= w_csum_nxt;
            if (w_len_bad) r_err <= 1'b1;
          end
        end
        S_DATA_LO: begin
          if (w_acc) begin
            r_lo   <= rx_data;
            r_csum <= w_csum_nxt;
          end
        end
        S_DATA_HI: begin
          if (w_acc) begin
            r_cr_we    <= 1'b1;
            r_cr_addr  <= r_cnt[ADDR_W-1:0];
            r_cr_wdata <= {rx_data, r_lo};
            r_csum     <= w_csum_nxt;
            r_cnt      <= w_cnt_inc;
          end
        end
        S_CSUM: begin
          if (w_acc && !w_csum_ok) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// tb/tb_j1_boot_ctrl.sv - directed self-checking bench for j1_boot_ctrl.
module tb_j1_boot_ctrl;

  logic        clk;
  logic        resetq;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        cr_we;
  logic [12:0] cr_addr;
  logic [15:0] cr_wdata;
  logic        cpu_resetq;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] wr_addr[$];
  logic [15:0] wr_data[$];

  j1_boot_ctrl #(.ADDR_W(13), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .resetq(resetq), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .cr_we(cr_we), .cr_addr(cr_addr),
    .cr_wdata(cr_wdata), .cpu_resetq(cpu_resetq), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetq && cr_we) begin
      wr_addr.push_back(cr_addr);
      wr_data.push_back(cr_wdata);
    end
  end

  // Sends n bytes back-to-back, most significant byte of v first.
  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rx_data  = v[8*i +: 8];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cpu_resetq, cr_we, err, busy, rx_ready} !== 5'b00001) begin
      n_errors++;
      $display("FAIL reset_ctrl: {cpu_resetq,cr_we,err,busy,rx_ready}=%b exp 00001",
               {cpu_resetq, cr_we, err, busy, rx_ready});
    end
    n_checks++;
    if (cr_addr !== 13'd0 || cr_wdata !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h exp 0 0", cr_addr, cr_wdata);
    end
    resetq = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    wr_addr.delete();
    wr_data.delete();
    send_bytes(64'hA5_02_00_34_12_CD_AB, 7);
    n_checks++;
    if (cpu_resetq !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL good_pre_csum: cpu_resetq=%b busy=%b exp 0 1", cpu_resetq, busy);
    end
    // 02^00^34^12^CD^AB = 0x42
    send_bytes(64'h42, 1);
    n_checks++;
    if ({cpu_resetq, err, rx_ready, busy} !== 4'b1000) begin
      n_errors++;
      $display("FAIL good_release: {cpu_resetq,err,rx_ready,busy}=%b exp 1000",
               {cpu_resetq, err, rx_ready, busy});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (wr_addr.size() != 2) begin
      n_errors++;
      $display("FAIL good_wr_count: got %0d exp 2", wr_addr.size());
    end else begin
      n_checks++;
      if (wr_addr[0] !== 13'd0 || wr_data[0] !== 16'h1234 ||
          wr_addr[1] !== 13'd1 || wr_data[1] !== 16'hABCD) begin
        n_errors++;
        $display("FAIL good_wr_data: %h:%h %h:%h exp 0000:1234 0001:abcd",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
    // Bytes offered while running stay with the UART.
    send_bytes(64'hA5, 1);
    n_checks++;
    if (cpu_resetq !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL run_ignores_rx: cpu_resetq=%b busy=%b rx_ready=%b exp 1 0 0",
               cpu_resetq, busy, rx_ready);
    end
  endtask

  task automatic test_bad_csum();
    pulse_reload();
    wr_addr.delete();
    wr_data.delete();
    send_bytes(64'hA5_02_00_34_12_CD_AB_00, 8);
    n_checks++;
    if ({cpu_resetq, err, rx_ready, busy} !== 4'b0110) begin
      n_errors++;
      $display("FAIL bad_csum: {cpu_resetq,err,rx_ready,busy}=%b exp 0110",
               {cpu_resetq, err, rx_ready, busy});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (wr_addr.size() != 2) begin
      n_errors++;
      $display("FAIL bad_csum_writes: got %0d exp 2", wr_addr.size());
    end
  endtask

  task automatic test_empty_frame();
    wr_addr.delete();
    send_bytes(64'hA5, 1);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL magic_clears_err: err=%b busy=%b exp 0 1", err, busy);
    end
    send_bytes(64'h00_00_00, 3);
    n_checks++;
    if (cpu_resetq !== 1'b1 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_release: cpu_resetq=%b err=%b exp 1 0", cpu_resetq, err);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (wr_addr.size() != 0) begin
      n_errors++;
      $display("FAIL empty_writes: got %0d exp 0", wr_addr.size());
    end
  endtask

  task automatic test_len_overflow();
    pulse_reload();
    wr_addr.delete();
    send_bytes(64'hA5_01_20, 3);
    n_checks++;
    if ({cpu_resetq, err, rx_ready, busy} !== 4'b0110) begin
      n_errors++;
      $display("FAIL len_overflow: {cpu_resetq,err,rx_ready,busy}=%b exp 0110",
               {cpu_resetq, err, rx_ready, busy});
    end
    send_bytes(64'h34_12_00, 3);
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1 || wr_addr.size() != 0) begin
      n_errors++;
      $display("FAIL overflow_discard: busy=%b err=%b writes=%0d exp 0 1 0",
               busy, err, wr_addr.size());
    end
    pulse_reload();
    n_checks++;
    if (busy !== 1'b0 || cpu_resetq !== 1'b0 || rx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reload_in_idle: busy=%b cpu_resetq=%b rx_ready=%b exp 0 0 1",
               busy, cpu_resetq, rx_ready);
    end
  endtask

  task automatic test_reload();
    // 01^00^EF^BE = 0x50
    send_bytes(64'hA5_01_00_EF_BE_50, 6);
    n_checks++;
    if (cpu_resetq !== 1'b1) begin
      n_errors++;
      $display("FAIL reload_first_release: cpu_resetq=%b exp 1", cpu_resetq);
    end
    pulse_reload();
    n_checks++;
    if (cpu_resetq !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reload_enter: cpu_resetq=%b rx_ready=%b busy=%b exp 0 1 0",
               cpu_resetq, rx_ready, busy);
    end
    wr_addr.delete();
    wr_data.delete();
    // 01^00^11^22 = 0x32
    send_bytes(64'hA5_01_00_11_22_32, 6);
    n_checks++;
    if (cpu_resetq !== 1'b1) begin
      n_errors++;
      $display("FAIL reload_rerelease: cpu_resetq=%b exp 1", cpu_resetq);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (wr_addr.size() != 1) begin
      n_errors++;
      $display("FAIL reload_wr_count: got %0d exp 1", wr_addr.size());
    end else begin
      n_checks++;
      if (wr_addr[0] !== 13'd0 || wr_data[0] !== 16'h2211) begin
        n_errors++;
        $display("FAIL reload_wr_data: %h:%h exp 0000:2211", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    pulse_reload();
    // N = 0x2000 is the largest legal length and must be accepted.
    send_bytes(64'hA5_00_20, 3);
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL max_len_accept: busy=%b err=%b exp 1 0", busy, err);
    end
    pulse_reload();
    n_checks++;
    if (busy !== 1'b1 || cpu_resetq !== 1'b0) begin
      n_errors++;
      $display("FAIL reload_mid_frame: busy=%b cpu_resetq=%b exp 1 0", busy, cpu_resetq);
    end
    resetq = 1'b0;
    #1;
    n_checks++;
    if ({cpu_resetq, cr_we, err, busy, rx_ready} !== 5'b00001 ||
        cr_addr !== 13'd0 || cr_wdata !== 16'd0) begin
      n_errors++;
      $display("FAIL async_reset: ctrl=%b addr=%h wdata=%h exp 00001 0 0",
               {cpu_resetq, cr_we, err, busy, rx_ready}, cr_addr, cr_wdata);
    end
    @(posedge clk);
    #1;
    resetq = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    send_bytes(64'h34, 1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_discard: busy=%b exp 0", busy);
    end
    // 01^00^78^56 = 0x2F
    send_bytes(64'hA5_01_00_78_56_2F, 6);
    @(negedge clk);
    #1;
    n_checks++;
    if (cpu_resetq !== 1'b1 || wr_addr.size() != 1) begin
      n_errors++;
      $display("FAIL post_reset_frame: cpu_resetq=%b writes=%0d exp 1 1",
               cpu_resetq, wr_addr.size());
    end else begin
      n_checks++;
      if (wr_addr[0] !== 13'd0 || wr_data[0] !== 16'h5678) begin
        n_errors++;
        $display("FAIL post_reset_wr: %h:%h exp 0000:5678", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_autostart();
    @(posedge clk);
    #1;
    resetq = 1'b0;
    #2;
    resetq = 1'b1;
`ifdef J1_BOOT_AUTOSTART_EN
    repeat (99) @(posedge clk);
    #1;
    n_checks++;
    if (cpu_resetq !== 1'b0) begin
      n_errors++;
      $display("FAIL autostart_early: cpu_resetq=%b exp 0 at cycle 99", cpu_resetq);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (cpu_resetq !== 1'b1 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL autostart_fire: cpu_resetq=%b err=%b exp 1 0", cpu_resetq, err);
    end
`else
    repeat (150) @(posedge clk);
    #1;
    n_checks++;
    if (cpu_resetq !== 1'b0 || rx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL no_autostart: cpu_resetq=%b rx_ready=%b exp 0 1", cpu_resetq, rx_ready);
    end
`endif
  endtask

  initial begin
    resetq   = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    reload   = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_empty_frame();
    test_len_overflow();
    test_reload();
    test_reset_mid_frame();
    test_autostart();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
